// File: rtl/csi2_packet_parser.sv
// CSI-2 packet parser: header/ECC check, frame tracking and payload extraction
// from merged 16-bit lane words, feeding the RAW10 decoder with pixel bytes only.
module csi2_packet_parser #(
    parameter logic [5:0] DATA_TYPE       = 6'h2B,
    parameter logic [1:0] VIRTUAL_CHANNEL = 2'd0
) (
    input  logic        rxbyteclkhs,
    input  logic        reset,
    input  logic [15:0] data_in,
    input  logic        in_valid,
    output logic [15:0] data_out,
    output logic        frame_active,
    output logic        frame_valid,
    output logic [15:0] line_count,
    output logic        ecc_error,
    output logic        trunc_error
);
    typedef enum logic [2:0] {IDLE, HDR2, PAYLOAD, CRC, WAIT_EOT} state_t;

    state_t      state;
    logic [7:0]  di;
    logic [7:0]  wcl;
    logic [15:0] remaining;
    logic        matching;

    logic [23:0] d;
    logic [5:0]  ecc_calc;
    logic        hdr_ok;
    logic [5:0]  dt;
    logic [1:0]  vc;

    // ECC covers {WCH, WCL, DI}; WCH and the ECC byte arrive in the HDR2 word
    assign d  = {data_in[15:8], wcl, di};
    assign dt = di[5:0];
    assign vc = di[7:6];

    always_comb begin
        ecc_calc    = '0;
        ecc_calc[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
        ecc_calc[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
        ecc_calc[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
        ecc_calc[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
        ecc_calc[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
        ecc_calc[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
    end

    assign hdr_ok = (data_in[7:0] == {2'b00, ecc_calc});

    always_ff @(posedge rxbyteclkhs) begin
        if (reset) begin
            state        <= IDLE;
            di           <= '0;
            wcl          <= '0;
            remaining    <= '0;
            matching     <= 1'b0;
            data_out     <= '0;
            frame_active <= 1'b0;
            frame_valid  <= 1'b0;
            line_count   <= '0;
            ecc_error    <= 1'b0;
            trunc_error  <= 1'b0;
        end else begin
            data_out     <= '0;
            frame_active <= 1'b0;
            ecc_error    <= 1'b0;
            trunc_error  <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        di    <= data_in[15:8];
                        wcl   <= data_in[7:0];
                        state <= HDR2;
                    end
                end
                HDR2: begin
                    if (!in_valid) begin
                        trunc_error <= 1'b1;
                        state       <= IDLE;
                    end else if (!hdr_ok) begin
                        ecc_error <= 1'b1;
                        state     <= WAIT_EOT;
                    end else if (dt < 6'h10) begin
                        if (vc == VIRTUAL_CHANNEL) begin
                            if (dt == 6'h00) begin
                                frame_valid <= 1'b1;
                                line_count  <= '0;
                            end else if (dt == 6'h01) begin
                                frame_valid <= 1'b0;
                            end
                        end
                        state <= WAIT_EOT;
                    end else begin
                        remaining <= {data_in[15:8], wcl};
                        matching  <= (dt == DATA_TYPE) && (vc == VIRTUAL_CHANNEL) && frame_valid;
                        state     <= ({data_in[15:8], wcl} == 16'd0) ? CRC : PAYLOAD;
                    end
                end
                PAYLOAD: begin
                    if (!in_valid) begin
                        trunc_error <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        if (matching) begin
                            frame_active <= 1'b1;
                            // odd WC: the low byte of the last word is already CRC
                            data_out     <= (remaining == 16'd1) ? {data_in[15:8], 8'h00} : data_in;
                        end
                        if (remaining <= 16'd2) begin
                            remaining <= '0;
                            if (matching)
                                line_count <= line_count + 16'd1;
                            state <= CRC;
                        end else begin
                            remaining <= remaining - 16'd2;
                        end
                    end
                end
                CRC: begin
                    if (!in_valid) begin
                        trunc_error <= 1'b1;
                        state       <= IDLE;
                    end else begin
                        state <= WAIT_EOT;
                    end
                end
                WAIT_EOT: begin
                    if (!in_valid)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_csi2_packet_parser.sv
// Scoreboard bench for csi2_packet_parser: directed CSI-2 bursts, expected
// payload words and error pulses queued at stimulus time, checked by a monitor.
module tb_csi2_packet_parser;
    logic        rxbyteclkhs = 1'b0;
    logic        reset;
    logic [15:0] data_in;
    logic        in_valid;
    logic [15:0] data_out;
    logic        frame_active;
    logic        frame_valid;
    logic [15:0] line_count;
    logic        ecc_error;
    logic        trunc_error;

    csi2_packet_parser dut (
        .rxbyteclkhs (rxbyteclkhs),
        .reset       (reset),
        .data_in     (data_in),
        .in_valid    (in_valid),
        .data_out    (data_out),
        .frame_active(frame_active),
        .frame_valid (frame_valid),
        .line_count  (line_count),
        .ecc_error   (ecc_error),
        .trunc_error (trunc_error)
    );

    always #5 rxbyteclkhs = ~rxbyteclkhs;

    typedef enum int {EV_PIX, EV_ECC, EV_TRUNC} kind_t;
    typedef struct {
        kind_t       kind;
        logic [15:0] data;
    } ev_t;

    ev_t evq[$];
    int  runq[$];
    int  vectors    = 0;
    int  miscompares = 0;
    bit  mon_en     = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // parity masks over D23..D0 = {WCH, WCL, DI}
    function automatic logic [7:0] ecc6(input logic [7:0] di, input logic [7:0] wcl, input logic [7:0] wch);
        logic [23:0] dd;
        logic [23:0] masks [6];
        logic [7:0]  e;
        dd = {wch, wcl, di};
        masks[0] = 24'hF12CB7;
        masks[1] = 24'hF2555B;
        masks[2] = 24'h749A6D;
        masks[3] = 24'hB8E38E;
        masks[4] = 24'hDF03F0;
        masks[5] = 24'hEFFC00;
        e = 8'h00;
        for (int k = 0; k < 6; k++) e[k] = ^(dd & masks[k]);
        return e;
    endfunction

    task automatic pop_expect(input kind_t kind, input logic [15:0] data, input string name);
        ev_t ev;
        if (evq.size() == 0) begin
            vectors++;
            miscompares++;
            $display("FAIL %s: unexpected output (data %0h), nothing queued at %0t", name, data, $time);
        end else begin
            ev = evq.pop_front();
            check({name, " kind"}, ev.kind, kind);
            if (kind == EV_PIX) check({name, " data"}, data, ev.data);
        end
    endtask

    int run = 0;
    always @(negedge rxbyteclkhs) begin
        if (mon_en) begin
            if (frame_active) begin
                run++;
                pop_expect(EV_PIX, data_out, "pixel");
            end else begin
                check("data_out idle zero", data_out, 16'h0);
                if (run > 0) begin
                    if (runq.size() == 0) begin
                        vectors++;
                        miscompares++;
                        $display("FAIL run length: unexpected run of %0d at %0t", run, $time);
                    end else begin
                        check("run length", run, runq.pop_front());
                    end
                    run = 0;
                end
            end
            if (ecc_error)   pop_expect(EV_ECC, 16'h0, "ecc_error");
            if (trunc_error) pop_expect(EV_TRUNC, 16'h0, "trunc_error");
        end
    end

    task automatic word(input logic [15:0] w);
        @(negedge rxbyteclkhs);
        data_in  = w;
        in_valid = 1'b1;
    endtask

    task automatic gap(input int n);
        repeat (n) begin
            @(negedge rxbyteclkhs);
            data_in  = 16'h0;
            in_valid = 1'b0;
        end
    endtask

    task automatic short_pkt(input logic [7:0] di, input logic [7:0] ecc);
        word({di, 8'h00});
        word({8'h00, ecc});
        gap(2);
    endtask

    // stop_after < 0: complete packet; else in_valid drops after that many payload words
    task automatic long_pkt(input logic [7:0] di, input logic [15:0] wc, input bit match, input int stop_after);
        int          nwords;
        int          sent;
        logic [15:0] w;
        ev_t         ev;
        nwords = (int'(wc) + 1) / 2;
        sent   = 0;
        word({di, wc[7:0]});
        word({wc[15:8], ecc6(di, wc[7:0], wc[15:8])});
        for (int i = 0; i < nwords; i++) begin
            if (stop_after >= 0 && i == stop_after) break;
            w = {8'(2*i+1), 8'(2*i+2)};
            if (match) begin
                ev.kind = EV_PIX;
                ev.data = (i == nwords-1 && wc[0]) ? {w[15:8], 8'h00} : w;
                evq.push_back(ev);
            end
            word(w);
            sent++;
        end
        if (stop_after >= 0) begin
            if (match && sent > 0) runq.push_back(sent);
            ev.kind = EV_TRUNC;
            ev.data = 16'h0;
            evq.push_back(ev);
        end else begin
            word(16'hC0C0);
            if (match && nwords > 0) runq.push_back(nwords);
        end
        gap(2);
    endtask

    initial begin
        ev_t ev;
        reset    = 1'b1;
        in_valid = 1'b0;
        data_in  = 16'h0;
        repeat (3) @(negedge rxbyteclkhs);
        check("reset data_out", data_out, 16'h0);
        check("reset frame_active", frame_active, 1'b0);
        check("reset frame_valid", frame_valid, 1'b0);
        check("reset line_count", line_count, 16'h0);
        check("reset ecc_error", ecc_error, 1'b0);
        check("reset trunc_error", trunc_error, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // frame start
        short_pkt(8'h00, 8'h00);
        check("FS frame_valid", frame_valid, 1'b1);
        check("FS line_count", line_count, 16'd0);

        long_pkt(8'h2B, 16'h000A, 1'b1, -1);
        check("even WC line_count", line_count, 16'd1);

        long_pkt(8'h2B, 16'h0009, 1'b1, -1);
        check("odd WC line_count", line_count, 16'd2);

        // corrupted FS header
        ev.kind = EV_ECC;
        ev.data = 16'h0;
        evq.push_back(ev);
        short_pkt(8'h00, 8'h01);
        check("bad ECC frame_valid", frame_valid, 1'b1);
        check("bad ECC line_count", line_count, 16'd2);

        // unrelated short packet type
        short_pkt(8'h08, ecc6(8'h08, 8'h00, 8'h00));
        check("generic short frame_valid", frame_valid, 1'b1);

        // frame end
        short_pkt(8'h01, 8'h07);
        check("FE frame_valid", frame_valid, 1'b0);

        // RAW10 outside a frame is not forwarded
        long_pkt(8'h2B, 16'h0004, 1'b0, -1);
        check("outside frame line_count", line_count, 16'd2);

        short_pkt(8'h00, 8'h00);
        check("FS2 line_count", line_count, 16'd0);

        long_pkt(8'h2A, 16'h000A, 1'b0, -1);
        check("RAW8 line_count", line_count, 16'd0);
        long_pkt(8'h6B, 16'h000A, 1'b0, -1);
        check("VC1 line_count", line_count, 16'd0);

        long_pkt(8'h2B, 16'h000A, 1'b1, 2);
        check("trunc line_count", line_count, 16'd0);
        check("trunc frame_valid", frame_valid, 1'b1);

        long_pkt(8'h2B, 16'h000A, 1'b1, -1);
        check("after trunc line_count", line_count, 16'd1);

        gap(4);
        check("event queue drained", evq.size(), 0);
        check("run queue drained", runq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/csi2_packet_parser.md
# csi2_packet_parser

Sits between the two-lane byte merger and the RAW10 decoder in the CSI-2 receive path. Consumes 16-bit merged lane words, parses CSI-2 short and long packet headers, and checks header ECC. Drives frame_valid from Frame Start/Frame End short packets and frame_active during matching long-packet payload. Strips headers, CRC and padding so the decoder sees only pixel bytes.

## Interface
- DATA_TYPE, 6'h2B, long-packet data type forwarded (RAW10)
- VIRTUAL_CHANNEL, 2'd0, virtual channel accepted; all others ignored
- rxbyteclkhs  in  1  byte clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- data_in  in  16  merged word; [15:8] earlier byte in stream order, [7:0] later byte
- in_valid  in  1  high for the whole HS burst after sync; low = EoT / idle
- data_out  out  16  payload word, same byte order as data_in
- frame_active  out  1  data_out carries payload of a matching long packet
- frame_valid  out  1  high between accepted FS and FE
- line_count  out  16  matching long packets delivered since last FS
- ecc_error  out  1  one-cycle pulse: header ECC mismatch
- trunc_error  out  1  one-cycle pulse: in_valid fell before payload and CRC were complete

## Operation
- Reset values:
  - data_out=0, frame_active=0, frame_valid=0, line_count=0, ecc_error=0, trunc_error=0.
  - State is IDLE.
  - A reset mid-packet aborts the packet with no error pulse.
- States are IDLE, HDR2, PAYLOAD, CRC, WAIT_EOT.
- IDLE: on the first in_valid word, latch DI=data_in[15:8] and WCL=data_in[7:0], then go to HDR2.
- HDR2: latch WCH=data_in[15:8] and ECC=data_in[7:0]. Compute the MIPI CSI-2 6-bit Hamming ECC over {WCH,WCL,DI}, bits D23..D0, with ECC[7:6] required 0.
  - ECC mismatch: pulse ecc_error, go to WAIT_EOT. frame_valid and line_count are unchanged.
  - Short packet (DT<0x10):
    - DT 0x00 with VC match: frame_valid<=1, line_count<=0. This also applies when frame_valid is already high.
    - DT 0x01 with VC match: frame_valid<=0. No effect if already low.
    - All other DT, or a VC mismatch: no effect.
    - Go to WAIT_EOT.
  - Long packet: load remaining=WC. Mark the packet as matching when DT==DATA_TYPE, VC==VIRTUAL_CHANNEL and frame_valid==1.
    - WC=0: go to CRC.
    - Otherwise: go to PAYLOAD.
- PAYLOAD: each in_valid word consumes min(2,remaining) bytes.
  - Matching packet: register data_out=data_in and frame_active=1.
  - If remaining==1, this is the odd WC case. data_out[7:0] is forced to 0x00 (CRC low byte masked), and CRC expects one more byte.
  - When remaining reaches 0:
    - Matching packet: line_count increments (16-bit wrap).
    - Go to CRC, or to WAIT_EOT when both CRC bytes are already consumed.
  - A non-matching packet is consumed silently with frame_active=0.
- CRC: consume the remaining CRC bytes (1 or 2; one word); CRC value is not checked. Go to WAIT_EOT.
- WAIT_EOT: ignore data_in until in_valid=0, then go to IDLE. Trailing padding and filler are discarded.
- in_valid=0 in HDR2, PAYLOAD or CRC: pulse trunc_error, frame_active<=0, go to IDLE. No line_count increment.
- in_valid=0 in IDLE: stay.

## Timing
- Input word sampled at edge t appears on data_out/frame_active after edge t+1: one-cycle registered latency.
- Header words produce frame_active=0.
- frame_active drops to 0 on the cycle after the last payload word is registered. This guarantees a low gap between lines, which resynchronises the downstream decoder.
- data_out holds 0 whenever frame_active=0.
- Payload words per long packet = ceil(WC/2). frame_active stays high contiguously across them.
- frame_valid changes one cycle after the FS/FE HDR2 word.
- ecc_error and trunc_error assert for exactly one cycle.

## Test plan
- FS burst 00 00 | 00 00, then in_valid low -> frame_valid=1 two edges after first word, line_count=0, ecc_error=0.
- After FS: long packet DI=0x2B, WC=0x000A, bench-model ECC, 5 payload words 0x0102..0x090A, CRC word -> frame_active high for exactly 5 consecutive cycles, data_out=0x0102..0x090A, line_count=1.
- Same long packet with WC=0x0009 -> 5 payload cycles, last data_out=0x0900, line_count increments.
- FS header with ECC byte 0x01 -> ecc_error single pulse, frame_valid unchanged; next FE 01 00 | 00 07 -> frame_valid=0.
- Long packet DT=0x2A (RAW8), or VC=1 -> frame_active never asserts, line_count unchanged.
- in_valid drops after 2 of 5 payload words -> trunc_error pulse, frame_active=0 the next cycle, line_count unchanged. Following packet parses normally.
